// File: rtl/maxbw_pkg.sv
// Shared definitions for the max-bandwidth PRBS tile: mode codes,
// checker state, ui_in bit positions and a small popcount helper.
package maxbw_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_GEN   = 2'b01,
    MODE_CHECK = 2'b10,
    MODE_LOOP  = 2'b11
  } mode_t;

  typedef enum logic {
    SYNC   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  localparam int CLR_BIT = 2;
  localparam int SEL_BIT = 3;
  localparam int INJ_BIT = 4;

  // Number of set bits in a byte; lanes narrower than 8 are zero-extended.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/prbs_adv.sv
// Advances a Fibonacci LFSR by WIDTH single-bit steps in one cycle,
// so a whole WIDTH-bit word of fresh sequence appears per clock.
module prbs_adv #(
  parameter int         WIDTH = 8,
  parameter logic [7:0] TAPS  = 8'hB8
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] MASK = TAPS[WIDTH-1:0];

  // Unrolled chain of single shifts; the newest bit enters at the LSB.
  always_comb begin
    logic [WIDTH-1:0] t;
    t = cur;
    for (int i = 0; i < WIDTH; i++) t = {t[WIDTH-2:0], ^(t & MASK)};
    nxt = t;
  end

endmodule

// File: rtl/tt_um_tommythorn_maxbw_prbs.sv
// TinyTapeout tile: PRBS pattern generator on uo_out/uio_out and a
// self-synchronising checker on uio_in with a saturating bit-error count.
module tt_um_tommythorn_maxbw_prbs
  import maxbw_pkg::*;
#(
  parameter int         WIDTH  = 8,
  parameter logic [7:0] TAPS   = 8'hB8,
  parameter logic [7:0] SEED   = 8'h01,
  parameter int         LOCK_N = 4,
  parameter int         LOSS_N = 8,
  parameter int         CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int MATCH_W = $clog2(LOCK_N + 1);
  localparam int LOSS_W  = $clog2(LOSS_N + 1);
  localparam int PC_W    = $clog2(WIDTH + 1);
  localparam int SUM_W   = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] ERR_MAX = SUM_W'({CNT_W{1'b1}});

  // Registered state
  logic [WIDTH-1:0]   gen, chk;
  chk_state_t         state;
  logic [MATCH_W-1:0] match_cnt;
  logic [LOSS_W-1:0]  loss_cnt;
  logic [CNT_W-1:0]   err_cnt;
  logic               sat, inj_q;

  // Next-state values
  logic [WIDTH-1:0]   gen_n, chk_n;
  chk_state_t         state_n;
  logic [MATCH_W-1:0] match_n;
  logic [LOSS_W-1:0]  loss_n;
  logic [CNT_W-1:0]   err_n;
  logic               sat_n;
  logic [7:0]         uo_n, uio_out_n, uio_oe_n;

  mode_t            mode;
  logic             clr, sel, inj_pulse, gen_run, chk_run;
  logic [WIDTH-1:0] rx, gen_adv, chk_exp, pat;
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] err_sum;
  logic             unused_bits;

  assign mode      = mode_t'(ui_in[1:0]);
  assign clr       = ui_in[CLR_BIT];
  assign sel       = ui_in[SEL_BIT];
  assign inj_pulse = ui_in[INJ_BIT] & ~inj_q;
  assign gen_run   = (mode == MODE_GEN) || (mode == MODE_LOOP);
  assign chk_run   = (mode == MODE_CHECK) || (mode == MODE_LOOP);
  assign rx        = uio_in[WIDTH-1:0];
  assign unused_bits = ^ui_in[7:5];

  prbs_adv #(.WIDTH(WIDTH), .TAPS(TAPS)) u_gen_adv (.cur(gen), .nxt(gen_adv));
  prbs_adv #(.WIDTH(WIDTH), .TAPS(TAPS)) u_chk_adv (.cur(chk), .nxt(chk_exp));

  assign pc      = PC_W'(popcount8(8'(rx ^ chk_exp)));
  assign err_sum = SUM_W'(err_cnt) + SUM_W'(pc);

  // Generator advance and checker SYNC/LOCKED transitions; clr overrides all.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    gen_n   = gen;
    chk_n   = chk;
    state_n = state;
    match_n = match_cnt;
    loss_n  = loss_cnt;
    err_n   = err_cnt;
    sat_n   = sat;
    if (clr) begin
      gen_n   = SEED[WIDTH-1:0];
      chk_n   = '0;
      state_n = SYNC;
      match_n = '0;
      loss_n  = '0;
      err_n   = '0;
      sat_n   = 1'b0;
    end else begin
      if (gen_run) gen_n = gen_adv;
      if (chk_run) begin
        case (state)
          SYNC: begin
            if (rx == '0) begin
              // An all-zero word is a dead link, never a valid PRBS word.
              match_n = '0;
            end else begin
              chk_n = rx;
              if (rx == chk_exp) begin
                if (match_cnt == MATCH_W'(LOCK_N - 1)) begin
                  state_n = LOCKED;
                  match_n = '0;
                end else begin
                  match_n = match_cnt + 1'b1;
                end
              end else begin
                match_n = '0;
              end
            end
          end
          LOCKED: begin
            // Flywheel: keep predicting from our own sequence.
            chk_n = chk_exp;
            if (err_sum >= ERR_MAX) begin
              err_n = '1;
              sat_n = 1'b1;
            end else begin
              err_n = CNT_W'(err_sum);
            end
            if (rx != chk_exp) begin
              if (loss_cnt == LOSS_W'(LOSS_N - 1)) begin
                state_n = SYNC;
                loss_n  = '0;
                match_n = '0;
              end else begin
                loss_n = loss_cnt + 1'b1;
              end
            end else begin
              loss_n = '0;
            end
          end
          default: state_n = SYNC;
        endcase
      end
    end
  end

  // Output word selection; outputs reflect the values being registered this edge.
  always_comb begin
    pat       = gen_n ^ {{(WIDTH-1){1'b0}}, inj_pulse};
    uo_n      = '0;
    uio_out_n = '0;
    uio_oe_n  = '0;
    case (mode)
      MODE_GEN: begin
        uo_n      = 8'(pat);
        uio_out_n = 8'(~pat);
        uio_oe_n  = 8'hFF;
      end
      MODE_LOOP: uo_n = 8'(pat);
      default:   uo_n = sel ? {state_n == LOCKED, sat_n, 6'b0} : 8'(err_n);
    endcase
  end

  // State and output registers; ena low freezes everything.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen       <= SEED[WIDTH-1:0];
      chk       <= '0;
      state     <= SYNC;
      match_cnt <= '0;
      loss_cnt  <= '0;
      err_cnt   <= '0;
      sat       <= 1'b0;
      inj_q     <= 1'b0;
      uo_out    <= '0;
      uio_out   <= '0;
      uio_oe    <= '0;
    end else if (ena) begin
      gen       <= gen_n;
      chk       <= chk_n;
      state     <= state_n;
      match_cnt <= match_n;
      loss_cnt  <= loss_n;
      err_cnt   <= err_n;
      sat       <= sat_n;
      inj_q     <= ui_in[INJ_BIT];
      uo_out    <= uo_n;
      uio_out   <= uio_out_n;
      uio_oe    <= uio_oe_n;
    end
  end

endmodule

// File: tb/tb_tt_um_tommythorn_maxbw_prbs.sv
// Self-checking bench for the PRBS tile. The reference sequence is built
// as a bit stream from the feedback recurrence and sliced into words.
module tb_tt_um_tommythorn_maxbw_prbs;

  localparam logic [7:0] SEED_V = 8'h01;
  localparam logic [7:0] TAPS_V = 8'hB8;
  localparam int         LOCK_N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       clr = 1'b0, sel = 1'b0, inj = 1'b0;
  logic       loopback = 1'b0;
  logic [7:0] uio_drv = 8'h00;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uo_out2, uio_out2, uio_oe2;

  int checks = 0;
  int failures = 0;
  logic [7:0] words [0:254];

  assign ui_in  = {3'b000, inj, sel, clr, mode};
  assign uio_in = loopback ? uo_out : uio_drv;

  tt_um_tommythorn_maxbw_prbs dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  tt_um_tommythorn_maxbw_prbs #(.LOSS_N(64)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out2),
    .uio_in(uio_in), .uio_out(uio_out2), .uio_oe(uio_oe2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit stream b[p] = XOR of b[p-1-i] over tap bits i; word k is the 8 bits
  // ending at position 8+8k, newest bit in the LSB.
  task automatic build_model();
    logic bits [0:2047];
    logic [7:0] taps, seed;
    logic b;
    taps = TAPS_V;
    seed = SEED_V;
    for (int i = 0; i < 8; i++) bits[7-i] = seed[i];
    for (int p = 8; p < 8 + 8 * 255; p++) begin
      b = 1'b0;
      for (int i = 0; i < 8; i++) if (taps[i]) b = b ^ bits[p-1-i];
      bits[p] = b;
    end
    for (int k = 0; k < 255; k++)
      for (int i = 0; i < 8; i++) words[k][i] = bits[8 + 8 * k - 1 - i];
  endtask

  function automatic logic [7:0] word_at(input int idx);
    return words[idx % 255];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    mode = 2'b01;
    repeat (3) tick();
    checks++; if (uo_out !== 8'h00) begin failures++; $display("FAIL reset_uo_out got %h want 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin failures++; $display("FAIL reset_uio_out got %h want 00", uio_out); end
    checks++; if (uio_oe !== 8'h00) begin failures++; $display("FAIL reset_uio_oe got %h want 00", uio_oe); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // GEN with random ena stalls: outputs hold while stalled, advance otherwise.
  task automatic test_gen();
    int n = 0;
    logic [7:0] exp;
    mode = 2'b01;
    for (int c = 0; c < 500 && n < 256; c++) begin
      ena = (c == 0) || ($urandom_range(0, 5) != 0);
      tick();
      if (ena) n++;
      exp = word_at(n);
      checks++; if (uo_out !== exp) begin failures++; $display("FAIL gen_word n=%0d got %h want %h", n, uo_out, exp); end
      checks++; if (uio_out !== ~exp) begin failures++; $display("FAIL gen_uio_out n=%0d got %h want %h", n, uio_out, ~exp); end
      checks++; if (uio_oe !== 8'hFF) begin failures++; $display("FAIL gen_uio_oe got %h want ff", uio_oe); end
    end
    checks++; if (n < 256) begin failures++; $display("FAIL gen_budget words %0d want 256", n); end
    ena = 1'b1;
  endtask

  task automatic test_loop();
    loopback = 1'b1;
    mode = 2'b11; sel = 1'b1;
    repeat (LOCK_N + 2) tick();
    mode = 2'b00;
    tick();
    checks++; if (uo_out !== 8'h80) begin failures++; $display("FAIL loop_locked got %h want 80", uo_out); end
    sel = 1'b0;
    tick();
    checks++; if (uo_out !== 8'h00) begin failures++; $display("FAIL loop_err got %h want 00", uo_out); end
  endtask

  task automatic test_inject();
    mode = 2'b11; clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (LOCK_N + 3 + $urandom_range(0, 5)) tick();
    for (int k = 0; k < 3; k++) begin
      inj = 1'b1; tick();
      inj = 1'b0; repeat (9) tick();
    end
    mode = 2'b00; sel = 1'b0;
    tick();
    checks++; if (uo_out !== 8'd3) begin failures++; $display("FAIL inject_err got %0d want 3", uo_out); end
    sel = 1'b1;
    tick();
    checks++; if (uo_out !== 8'h80) begin failures++; $display("FAIL inject_locked got %h want 80", uo_out); end
  endtask

  task automatic test_check_zero();
    loopback = 1'b0; uio_drv = 8'h00;
    mode = 2'b10; sel = 1'b1; clr = 1'b1;
    tick();
    checks++; if (uo_out !== 8'h00) begin failures++; $display("FAIL clr_status got %h want 00", uo_out); end
    clr = 1'b0;
    repeat ($urandom_range(10, 30)) tick();
    checks++; if (uo_out !== 8'h00) begin failures++; $display("FAIL zero_sync got %h want 00", uo_out); end
    sel = 1'b0;
    tick();
    checks++; if (uo_out !== 8'h00) begin failures++; $display("FAIL zero_err got %h want 00", uo_out); end
  endtask

  task automatic test_invert_relock();
    int s = $urandom_range(0, 254);
    mode = 2'b10; sel = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 6; k++) begin uio_drv = word_at(s + k); tick(); end
    checks++; if (uo_out !== 8'h80) begin failures++; $display("FAIL inv_lock got %h want 80", uo_out); end
    for (int j = 0; j < 8; j++) begin
      uio_drv = ~word_at(s + 6 + j);
      tick();
      if (j == 6) begin
        checks++; if (uo_out !== 8'h80) begin failures++; $display("FAIL inv_hold7 got %h want 80", uo_out); end
      end
    end
    checks++; if (uo_out !== 8'h00) begin failures++; $display("FAIL inv_drop got %h want 00", uo_out); end
    mode = 2'b00; sel = 1'b0;
    tick();
    checks++; if (uo_out !== 8'd64) begin failures++; $display("FAIL inv_err got %0d want 64", uo_out); end
    mode = 2'b10; sel = 1'b1;
    for (int k = 0; k < LOCK_N; k++) begin
      uio_drv = word_at(s + 14 + k);
      tick();
      if (k < LOCK_N - 1) begin
        checks++; if (uo_out !== 8'h00) begin failures++; $display("FAIL relock_early k=%0d got %h want 00", k, uo_out); end
      end
    end
    checks++; if (uo_out !== 8'h80) begin failures++; $display("FAIL relock got %h want 80", uo_out); end
  endtask

  task automatic test_saturation();
    int s = $urandom_range(0, 254);
    mode = 2'b10; sel = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 6; k++) begin uio_drv = word_at(s + k); tick(); end
    checks++; if (uo_out2 !== 8'h80) begin failures++; $display("FAIL sat_lock got %h want 80", uo_out2); end
    for (int j = 0; j < 40; j++) begin uio_drv = ~word_at(s + 6 + j); tick(); end
    mode = 2'b00; sel = 1'b0;
    tick();
    checks++; if (uo_out2 !== 8'hFF) begin failures++; $display("FAIL sat_err got %h want ff", uo_out2); end
    sel = 1'b1;
    tick();
    checks++; if (uo_out2 !== 8'hC0) begin failures++; $display("FAIL sat_status got %h want c0", uo_out2); end
  endtask

  task automatic test_async_reset();
    mode = 2'b01; sel = 1'b0;
    repeat (3) tick();
    checks++; if (uio_oe !== 8'hFF) begin failures++; $display("FAIL pre_reset_oe got %h want ff", uio_oe); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({uo_out, uio_out, uio_oe} !== 24'h0) begin failures++; $display("FAIL async_reset got %h %h %h want 00 00 00", uo_out, uio_out, uio_oe); end
    checks++; if ({uo_out2, uio_out2, uio_oe2} !== 24'h0) begin failures++; $display("FAIL async_reset2 got %h %h %h want 00 00 00", uo_out2, uio_out2, uio_oe2); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (uo_out !== word_at(1)) begin failures++; $display("FAIL post_reset_word got %h want %h", uo_out, word_at(1)); end
    repeat ($urandom_range(2, 20)) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (uo_out !== SEED_V) begin failures++; $display("FAIL gen_clr got %h want %h", uo_out, SEED_V); end
    tick();
    checks++; if (uo_out !== word_at(1)) begin failures++; $display("FAIL gen_after_clr got %h want %h", uo_out, word_at(1)); end
  endtask

  initial begin
    build_model();
    test_reset();
    test_gen();
    test_loop();
    test_inject();
    test_check_zero();
    test_invert_relock();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
